// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon master port between instruction-fetch (I) and load/store (D) requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority with D winning ties.
module mips_bus_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] i_address,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [31:0] i_writedata,
  input  logic [3:0]  i_byteenable,
  output logic        i_waitrequest,
  output logic        i_readdatavalid,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic        d_readdatavalid,
  output logic [31:0] readdata_out,
  output logic [31:0] address,
  output logic [31:0] writedata,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD_I = 2'd1,
    ST_HOLD_D = 2'd2
  } state_t;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  state_t r_state;
  logic   r_rpend;
  logic   r_rsel;
  logic   r_last;

  logic   w_req_i;
  logic   w_req_d;
  logic   w_gnt_vld;
  logic   w_gnt_d;
  logic   w_bus_rd;
  logic   w_accept;

  assign w_req_i = i_read | i_write;
  assign w_req_d = d_read | d_write;

  // Grant selection; the bus port is forced quiet while reset is asserted.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_d   = SEL_I;
    if (!reset_n) begin
      w_gnt_vld = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_i && w_req_d) begin
            w_gnt_vld = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            w_gnt_d   = ~r_last;
`else
            w_gnt_d   = SEL_D;
`endif
          end else if (w_req_d) begin
            w_gnt_vld = 1'b1;
            w_gnt_d   = SEL_D;
          end else if (w_req_i) begin
            w_gnt_vld = 1'b1;
            w_gnt_d   = SEL_I;
          end else begin
            w_gnt_vld = 1'b0;
          end
        end
        ST_HOLD_I: begin
          w_gnt_vld = 1'b1;
          w_gnt_d   = SEL_I;
        end
        ST_HOLD_D: begin
          w_gnt_vld = 1'b1;
          w_gnt_d   = SEL_D;
        end
        default: begin
          w_gnt_vld = 1'b0;
        end
      endcase
    end
  end

  // Steer the granted requester onto the bus; a simultaneous read+write becomes a write.
  always_comb begin
    address       = 32'd0;
    writedata     = 32'd0;
    byteenable    = 4'd0;
    w_bus_rd      = 1'b0;
    write         = 1'b0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    if (w_gnt_vld) begin
      if (w_gnt_d) begin
        address       = d_address;
        writedata     = d_writedata;
        byteenable    = d_byteenable;
        w_bus_rd      = d_read & ~d_write;
        write         = d_write;
        d_waitrequest = waitrequest;
      end else begin
        address       = i_address;
        writedata     = i_writedata;
        byteenable    = i_byteenable;
        w_bus_rd      = i_read & ~i_write;
        write         = i_write;
        i_waitrequest = waitrequest;
      end
    end else begin
      w_bus_rd = 1'b0;
    end
  end

  assign read     = w_bus_rd;
  assign w_accept = w_gnt_vld & ~waitrequest;

  // Grant lock across stalls, readback routing and last-accepted tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_rpend <= 1'b0;
      r_rsel  <= SEL_I;
      r_last  <= SEL_D;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld && waitrequest) begin
            r_state <= w_gnt_d ? ST_HOLD_D : ST_HOLD_I;
          end
        end
        ST_HOLD_I, ST_HOLD_D: begin
          if (!waitrequest) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      r_rpend <= w_accept & w_bus_rd;
      if (w_accept) begin
        r_rsel <= w_gnt_d;
        r_last <= w_gnt_d;
      end
    end
  end

  assign i_readdatavalid = r_rpend & (r_rsel == SEL_I);
  assign d_readdatavalid = r_rpend & (r_rsel == SEL_D);
  assign readdata_out    = readdata;

endmodule
